div16x8_seq: RTL and testbench



---
 rtl/div_pkg.sv | 24 ++
 rtl/div_step.sv | 28 ++
 rtl/div16x8_seq.sv | 109 ++++++++++
 tb/tb_div16x8_seq.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the sequential 16/8 restoring divider.
// DIV_RADIX4_EN selects two quotient bits per CALC cycle instead of one.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

  localparam int DW_DEF = 16;
  localparam int VW_DEF = 8;

`ifdef DIV_RADIX4_EN
  localparam int ITER_COUNT = 8;
`else
  localparam int ITER_COUNT = 16;
`endif

  localparam int STEPS_PER_CYCLE = DW_DEF / ITER_COUNT;

  localparam logic [DW_DEF-1:0] DZ_QUOT = 16'hFFFF;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in a dividend bit and
// conditionally subtract the divisor from the 9-bit partial remainder.
module div_step #(
  parameter int VW = 8
) (
  input  logic [VW:0]   r_in,
  input  logic          q_msb,
  input  logic [VW-1:0] d,
  output logic [VW:0]   r_out,
  output logic          q_bit
);

  logic [VW:0] r_sh;
  logic [VW:0] d_ext;

  assign r_sh  = {r_in[VW-1:0], q_msb};
  assign d_ext = {1'b0, d};

  always_comb begin
    r_out = r_sh;
    q_bit = 1'b0;
    if (r_sh >= d_ext) begin
      r_out = r_sh - d_ext;
      q_bit = 1'b1;
    end
  end

endmodule

// File: rtl/div16x8_seq.sv
// Start/done sequential restoring divider, 16-bit dividend by 8-bit divisor.
// Build with DIV_RADIX4_EN to chain two steps per cycle (8 CALC cycles).
module div16x8_seq
  import div_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int VW = VW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_by_zero
);

  localparam int STEPS = STEPS_PER_CYCLE;
  localparam int CNT_W = $clog2(ITER_COUNT);

  div_state_t state_reg, state_next;

  logic [DW-1:0]    q_reg;
  logic [VW-1:0]    d_reg;
  logic [VW:0]      r_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             last_step;

  logic [VW:0]      r_chain [0:STEPS];
  logic [STEPS-1:0] q_bits;
  logic [DW-1:0]    q_next;

  assign r_chain[0] = r_reg;

  // Each chained step consumes the next dividend bit from the MSB downwards.
  generate
    for (genvar gi = 0; gi < STEPS; gi++) begin : g_step
      div_step #(.VW(VW)) u_step (
        .r_in  (r_chain[gi]),
        .q_msb (q_reg[DW-1-gi]),
        .d     (d_reg),
        .r_out (r_chain[gi+1]),
        .q_bit (q_bits[STEPS-1-gi])
      );
    end
  endgenerate

  assign q_next    = {q_reg[DW-1-STEPS:0], q_bits};
  assign last_step = (cnt_reg == CNT_W'(ITER_COUNT - 1));

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (start) state_next = (divisor == '0) ? DONE : CALC;
      CALC: if (last_step) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_reg != IDLE);
    done = (state_reg == DONE);
  end

  // Results are written only on the transition into DONE, so the previous
  // result stays visible while a new division is in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_reg       <= '0;
      d_reg       <= '0;
      r_reg       <= '0;
      cnt_reg     <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (state_reg == IDLE) begin
      if (start) begin
        q_reg       <= dividend;
        d_reg       <= divisor;
        r_reg       <= '0;
        cnt_reg     <= '0;
        div_by_zero <= 1'b0;
        if (divisor == '0) begin
          quotient    <= DZ_QUOT;
          remainder   <= dividend[VW-1:0];
          div_by_zero <= 1'b1;
        end
      end
    end else if (state_reg == CALC) begin
      q_reg   <= q_next;
      r_reg   <= r_chain[STEPS];
      cnt_reg <= cnt_reg + CNT_W'(1);
      if (last_step) begin
        quotient  <= q_next;
        remainder <= r_chain[STEPS][VW-1:0];
      end
    end
  end

endmodule

// File: tb/tb_div16x8_seq.sv
// Directed and randomised checks of div16x8_seq latency, results and control.
module tb_div16x8_seq;

`ifdef DIV_RADIX4_EN
  localparam int LAT = 9;
`else
  localparam int LAT = 17;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] dividend = '0;
  logic [7:0]  divisor = '0;
  logic        busy, done, div_by_zero;
  logic [15:0] quotient;
  logic [7:0]  remainder;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  div16x8_seq dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  // Waits for idle, issues one start, returns the cycle number of done (40 = timeout).
  task automatic run_op(input logic [15:0] dd, input logic [7:0] dv, output int lat);
    int guard = 0;
    @(negedge clk);
    while (busy && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    start = 1'b1; dividend = dd; divisor = dv;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({busy, done, quotient, remainder, div_by_zero} !== 27'd0) begin
      bad++;
      $display("FAIL reset_outputs got=%h want=0", {busy, done, quotient, remainder, div_by_zero});
    end
    rst = 1'b0;
    $display("reset: busy=%0b done=%0b q=%0d r=%0d dz=%0b", busy, done, quotient, remainder, div_by_zero);
  endtask

  task automatic test_basic(input logic [15:0] dd, input logic [7:0] dv,
                            input logic [15:0] eq, input logic [7:0] er);
    int lat;
    run_op(dd, dv, lat);
    $display("op %0d/%0d: lat=%0d q=%0d r=%0d dz=%0b", dd, dv, lat, quotient, remainder, div_by_zero);
    total++;
    if (lat !== LAT) begin bad++; $display("FAIL basic_latency %0d/%0d got=%0d want=%0d", dd, dv, lat, LAT); end
    total++;
    if (quotient !== eq) begin bad++; $display("FAIL basic_quotient %0d/%0d got=%0d want=%0d", dd, dv, quotient, eq); end
    total++;
    if (remainder !== er) begin bad++; $display("FAIL basic_remainder %0d/%0d got=%0d want=%0d", dd, dv, remainder, er); end
    total++;
    if (div_by_zero !== 1'b0) begin bad++; $display("FAIL basic_dz %0d/%0d got=%0b want=0", dd, dv, div_by_zero); end
  endtask

  task automatic test_div_zero();
    int lat;
    run_op(16'h1234, 8'd0, lat);
    $display("op 0x1234/0: lat=%0d q=%h r=%h dz=%0b", lat, quotient, remainder, div_by_zero);
    total++;
    if (lat !== 1) begin bad++; $display("FAIL dz_latency got=%0d want=1", lat); end
    total++;
    if (quotient !== 16'hFFFF) begin bad++; $display("FAIL dz_quotient got=%h want=ffff", quotient); end
    total++;
    if (remainder !== 8'h34) begin bad++; $display("FAIL dz_remainder got=%h want=34", remainder); end
    total++;
    if (div_by_zero !== 1'b1) begin bad++; $display("FAIL dz_flag got=%0b want=1", div_by_zero); end
    test_basic(16'd50, 8'd5, 16'd10, 8'd0);
  endtask

  task automatic test_ignore_busy();
    int lat;
    int extra = 0;
    @(negedge clk);
    while (busy) @(negedge clk);
    start = 1'b1; dividend = 16'd1000; divisor = 8'd7;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    while (!done && lat < 40) begin
      if (lat == 4) begin start = 1'b1; dividend = 16'd9; divisor = 8'd3; end
      else begin start = 1'b0; end
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    $display("op 1000/7 with start while busy: lat=%0d q=%0d r=%0d", lat, quotient, remainder);
    total++;
    if (lat !== LAT) begin bad++; $display("FAIL ignore_latency got=%0d want=%0d", lat, LAT); end
    total++;
    if ({quotient, remainder} !== {16'd142, 8'd6}) begin
      bad++; $display("FAIL ignore_result got=%0d/%0d want=142/6", quotient, remainder);
    end
    repeat (25) begin
      @(posedge clk); #1;
      if (done) extra++;
    end
    total++;
    if (extra !== 0) begin bad++; $display("FAIL ignore_second_done got=%0d want=0", extra); end
  endtask

  task automatic test_mid_reset();
    int dones = 0;
    @(negedge clk);
    while (busy) @(negedge clk);
    start = 1'b1; dividend = 16'd1000; divisor = 8'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    $display("mid reset: busy=%0b done=%0b q=%0d r=%0d dz=%0b", busy, done, quotient, remainder, div_by_zero);
    total++;
    if ({busy, done, quotient, remainder, div_by_zero} !== 27'd0) begin
      bad++; $display("FAIL midreset_outputs got=%h want=0", {busy, done, quotient, remainder, div_by_zero});
    end
    rst = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done || busy) dones++;
    end
    total++;
    if (dones !== 0) begin bad++; $display("FAIL midreset_activity got=%0d want=0", dones); end
    test_basic(16'd1000, 8'd7, 16'd142, 8'd6);
  endtask

  task automatic test_random();
    int lat;
    logic [15:0] dd, eq;
    logic [7:0]  dv, er;
    for (int i = 0; i < 500; i++) begin
      dd = 16'($urandom);
      dv = 8'($urandom_range(1, 255));
      if (i % 5 == 1) dv = 8'd1;
      if (i % 5 == 2) dv = 8'd255;
      if (i % 5 == 3) dd = 16'($urandom_range(0, int'(dv) - 1));
      eq = dd / 16'(dv);
      er = 8'(dd % 16'(dv));
      run_op(dd, dv, lat);
      $display("rand %0d: %0d/%0d lat=%0d q=%0d r=%0d", i, dd, dv, lat, quotient, remainder);
      total++;
      if (lat !== LAT) begin bad++; $display("FAIL rand_latency %0d got=%0d want=%0d", i, lat, LAT); end
      total++;
      if ({quotient, remainder, div_by_zero} !== {eq, er, 1'b0}) begin
        bad++; $display("FAIL rand_result %0d %0d/%0d got=%0d,%0d,%0b want=%0d,%0d,0",
                        i, dd, dv, quotient, remainder, div_by_zero, eq, er);
      end
      total++;
      if ((32'(quotient) * 32'(dv) + 32'(remainder) !== 32'(dd)) || (remainder >= dv)) begin
        bad++; $display("FAIL rand_invariant %0d got q=%0d r=%0d want dividend=%0d", i, quotient, remainder, dd);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic(16'd1000, 8'd7, 16'd142, 8'd6);
    test_basic(16'd65535, 8'd1, 16'hFFFF, 8'd0);
    test_basic(16'd200, 8'd255, 16'd0, 8'd200);
    test_div_zero();
    test_ignore_busy();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
